// File: rtl/ram_stream_reader.sv
// ram_stream_reader: drives the read address of a synchronous RAM and streams a
// contiguous region out one byte at a time. After each address change it waits
// out the RAM read latency, presents the byte with a valid/ready handshake, and
// keeps a running modulo-2^DW sum of the bytes the consumer has accepted.
//
// Handshake: rd_valid rises together with a new rd_data. While rd_valid=1 both
// rd_data and address stay unchanged until the consumer holds rd_ready=1 at a
// rising edge of clk, and the byte transfers at that edge. rd_ready has no
// effect while rd_valid=0.
module ram_stream_reader #(
    parameter int AW       = 14,
    parameter int DW       = 8,
    parameter int READ_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,        // asynchronous, active low
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   length,
    input  logic [DW-1:0] q,
    output logic [AW-1:0] address,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] checksum,
    output logic [1:0]    dbg_state
);

    // wcnt counts the edges spent in WAIT. It is 2 bits wide because READ_LAT is at most 3.
    localparam logic [1:0] LAT = 2'(READ_LAT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_PRESENT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] address_q, address_d;
    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          done_q, done_d;
    logic [DW-1:0] checksum_q, checksum_d;
    logic [AW:0]   remaining_q, remaining_d;
    logic [1:0]    wcnt_q, wcnt_d;

    // Next-state and next-output computation for the stream controller
    always_comb begin
        state_d     = state_q;
        address_d   = address_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = rd_valid_q;
        done_d      = 1'b0;
        checksum_d  = checksum_q;
        remaining_d = remaining_q;
        wcnt_d      = wcnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    checksum_d = '0;
                    if (length != '0) begin
                        address_d   = base_addr;
                        remaining_d = length;
                        wcnt_d      = 2'd0;
                        state_d     = S_WAIT;
                    end else begin
                        // An empty region completes immediately without touching the RAM
                        done_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (abort) begin
                    rd_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end else if (wcnt_q == LAT) begin
                    // q now reflects the address that has been held since entering WAIT
                    rd_data_d  = q;
                    rd_valid_d = 1'b1;
                    state_d    = S_PRESENT;
                end else begin
                    wcnt_d = wcnt_q + 2'd1;
                end
            end
            S_PRESENT: begin
                // abort wins over a transfer at the same edge, so that byte is not summed
                if (abort) begin
                    rd_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end else if (rd_ready) begin
                    checksum_d  = checksum_q + rd_data_q;
                    remaining_d = remaining_q - (AW+1)'(1);
                    rd_valid_d  = 1'b0;
                    if (remaining_q == (AW+1)'(1)) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        // Wraps from the top of memory back to address 0
                        address_d = address_q + AW'(1);
                        wcnt_d    = 2'd0;
                        state_d   = S_WAIT;
                    end
                end
            end
            default: begin
                rd_valid_d = 1'b0;
                state_d    = S_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            address_q   <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            done_q      <= 1'b0;
            checksum_q  <= '0;
            remaining_q <= '0;
            wcnt_q      <= 2'd0;
        end else begin
            state_q     <= state_d;
            address_q   <= address_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            done_q      <= done_d;
            checksum_q  <= checksum_d;
            remaining_q <= remaining_d;
            wcnt_q      <= wcnt_d;
        end
    end

    assign address   = address_q;
    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign done      = done_q;
    assign checksum  = checksum_q;
    assign busy      = (state_q != S_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Testbench for ram_stream_reader: a 16K x 8 RAM model with a one-edge read
// latency feeds the reader. Each scenario task drives a stream and compares what
// the consumer received against the byte sequence and sum computed directly
// from the RAM contents.
module tb_ram_stream_reader;

    localparam int AW       = 14;
    localparam int DW       = 8;
    localparam int READ_LAT = 1;
    localparam int DEPTH    = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic [DW-1:0] q;
    logic [AW-1:0] address;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_ready;
    logic          busy;
    logic          done;
    logic [DW-1:0] checksum;
    logic [1:0]    dbg_state;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] mem [0:DEPTH-1];

    // Results gathered by run_stream
    logic [DW-1:0] got_q[$];
    logic [AW-1:0] got_addr_q[$];
    int            xfer_cyc_q[$];
    int            first_valid;
    int            done_cnt;
    int            stable_viol;
    int            busy_viol;
    logic          busy_at_done;
    int            timed_out;

    // Expectations built from the RAM contents
    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] exp_addr_q[$];
    logic [DW-1:0] exp_sum;

    ram_stream_reader #(.AW(AW), .DW(DW), .READ_LAT(READ_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .base_addr(base_addr), .length(length), .q(q),
        .address(address), .rd_data(rd_data), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .busy(busy), .done(done),
        .checksum(checksum), .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // RAM model: synchronous read, q follows the address one edge later
    always @(posedge clk) q <= mem[address];

    // Region i-th byte lives at (base + i) mod DEPTH; sum is taken mod 256
    function automatic void build_exp(input int b, input int n);
        int s;
        s = 0;
        exp_q.delete();
        exp_addr_q.delete();
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(mem[(b + i) % DEPTH]);
            exp_addr_q.push_back(AW'((b + i) % DEPTH));
            s = s + int'(mem[(b + i) % DEPTH]);
        end
        exp_sum = DW'(s % 256);
    endfunction

    function automatic int byte_mismatches();
        int m;
        m = (got_q.size() != exp_q.size()) ? 1 : 0;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) m++;
        return m;
    endfunction

    function automatic int addr_mismatches();
        int m;
        m = (got_addr_q.size() != exp_addr_q.size()) ? 1 : 0;
        for (int i = 0; i < got_addr_q.size() && i < exp_addr_q.size(); i++)
            if (got_addr_q[i] !== exp_addr_q[i]) m++;
        return m;
    endfunction

    // Driver: start a stream at the next negedge and act as consumer until done
    // (plus two cycles) or abort. Cycle 0 is the cycle in which start is driven.
    // pct: chance of rd_ready each cycle; hold_idx/hold_n: stall that byte;
    // poke_cyc: drive a second start in that cycle; abort_idx: abort on that byte.
    task automatic run_stream(input int b, input int n, input int pct,
                              input int hold_idx, input int hold_n,
                              input int poke_cyc, input int abort_idx);
        int            cyc, post, hold_cnt, budget;
        logic          done_seen, prev_stall, ready;
        logic [DW-1:0] prev_data;
        logic [AW-1:0] prev_addr;
        got_q.delete();
        got_addr_q.delete();
        xfer_cyc_q.delete();
        first_valid = 0; done_cnt = 0; stable_viol = 0; busy_viol = 0;
        busy_at_done = 1'bx; timed_out = 0;
        cyc = 0; post = 0; hold_cnt = 0; done_seen = 0; prev_stall = 0;
        prev_data = '0; prev_addr = '0;
        budget = 100 + n * 40;
        @(negedge clk);
        start = 1'b1; abort = 1'b0; rd_ready = 1'b0;
        base_addr = AW'(b); length = (AW+1)'(n);
        while (1) begin
            @(negedge clk);
            cyc++;
            start     = (cyc == poke_cyc);
            abort     = 1'b0;
            base_addr = AW'($urandom);
            length    = (AW+1)'($urandom_range(1, 40));
            if (rd_valid === 1'b1 && first_valid == 0) first_valid = cyc;
            if (prev_stall && (rd_valid !== 1'b1 || rd_data !== prev_data || address !== prev_addr))
                stable_viol++;
            if (done === 1'b1) begin
                done_cnt++;
                if (!done_seen) busy_at_done = busy;
                done_seen = 1'b1;
            end else if (!done_seen && busy !== 1'b1) begin
                busy_viol++;
            end
            if (done_seen) begin
                post++;
                if (post > 2) break;
            end
            ready = ($urandom_range(99) < pct);
            if (rd_valid === 1'b1 && got_q.size() == hold_idx && hold_cnt < hold_n) begin
                ready = 1'b0;
                hold_cnt++;
            end
            if (rd_valid === 1'b1 && got_q.size() == abort_idx) begin
                abort    = 1'b1;
                rd_ready = 1'b1;
                break;
            end
            rd_ready   = ready;
            prev_stall = (rd_valid === 1'b1) && !ready;
            prev_data  = rd_data;
            prev_addr  = address;
            if (rd_valid === 1'b1 && ready) begin
                got_q.push_back(rd_data);
                got_addr_q.push_back(address);
                xfer_cyc_q.push_back(cyc);
            end
            if (cyc > budget) begin
                timed_out = 1;
                break;
            end
        end
        start = 1'b0;
        if (abort_idx < 0) rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; abort = 1'b0; rd_ready = 1'b0;
        base_addr = '0; length = '0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (address !== '0) begin errors++; $display("FAIL reset_address: got %0d expected 0", address); end
        checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data: got %0h expected 0", rd_data); end
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (checksum !== '0) begin errors++; $display("FAIL reset_checksum: got %0h expected 0", checksum); end
    endtask

    task automatic test_basic();
        int bad_gap;
        mem[100] = 8'h11; mem[101] = 8'h22; mem[102] = 8'h33; mem[103] = 8'h44;
        build_exp(100, 4);
        run_stream(100, 4, 100, -1, 0, 0, -1);
        bad_gap = 0;
        for (int i = 1; i < xfer_cyc_q.size(); i++)
            if (xfer_cyc_q[i] - xfer_cyc_q[i-1] != READ_LAT + 2) bad_gap++;
        checks++; if (timed_out != 0) begin errors++; $display("FAIL basic_timeout: stream did not finish"); end
        checks++; if (byte_mismatches() != 0) begin errors++; $display("FAIL basic_bytes: %0d mismatches, %0d bytes got, 4 expected", byte_mismatches(), got_q.size()); end
        checks++; if (addr_mismatches() != 0) begin errors++; $display("FAIL basic_addr: %0d mismatches expected 0", addr_mismatches()); end
        checks++; if (first_valid != READ_LAT + 2) begin errors++; $display("FAIL basic_latency: first valid at cycle %0d expected %0d", first_valid, READ_LAT + 2); end
        checks++; if (bad_gap != 0) begin errors++; $display("FAIL basic_throughput: %0d gaps differ from %0d cycles", bad_gap, READ_LAT + 2); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done: %0d pulses expected 1", done_cnt); end
        checks++; if (busy_at_done !== 1'b0 || busy_viol != 0) begin errors++; $display("FAIL basic_busy: busy at done %b, %0d early drops", busy_at_done, busy_viol); end
        checks++; if (checksum !== 8'hAA) begin errors++; $display("FAIL basic_checksum: got %0h expected aa", checksum); end
    endtask

    task automatic test_backpressure();
        build_exp(100, 4);
        run_stream(100, 4, 100, 1, 5, 0, -1);
        checks++; if (got_q.size() != 4 || byte_mismatches() != 0) begin errors++; $display("FAIL bp_bytes: %0d transfers, %0d mismatches, expected 4 and 0", got_q.size(), byte_mismatches()); end
        checks++; if (stable_viol != 0) begin errors++; $display("FAIL bp_stable: %0d stall cycles changed data/address, expected 0", stable_viol); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done: %0d pulses expected 1", done_cnt); end
        checks++; if (checksum !== 8'hAA) begin errors++; $display("FAIL bp_checksum: got %0h expected aa", checksum); end
    endtask

    task automatic test_wrap();
        mem[DEPTH-1] = 8'hFF; mem[0] = 8'h01; mem[1] = 8'h02;
        build_exp(DEPTH - 1, 3);
        run_stream(DEPTH - 1, 3, 100, -1, 0, 0, -1);
        checks++; if (addr_mismatches() != 0) begin errors++; $display("FAIL wrap_addr: %0d mismatches expected 0", addr_mismatches()); end
        checks++; if (byte_mismatches() != 0) begin errors++; $display("FAIL wrap_bytes: %0d mismatches expected 0", byte_mismatches()); end
        checks++; if (checksum !== 8'h02) begin errors++; $display("FAIL wrap_checksum: got %0h expected 02", checksum); end
    endtask

    task automatic test_zero_length();
        @(negedge clk);
        start = 1'b1; base_addr = AW'($urandom); length = '0;
        @(negedge clk);
        start = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b expected 1", done); end
        checks++; if (rd_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL zero_idle: rd_valid %b busy %b expected 0 0", rd_valid, busy); end
        checks++; if (checksum !== '0) begin errors++; $display("FAIL zero_checksum: got %0h expected 0", checksum); end
        @(negedge clk);
        checks++; if (done !== 1'b0 || rd_valid !== 1'b0) begin errors++; $display("FAIL zero_pulse: done %b rd_valid %b expected 0 0", done, rd_valid); end
    endtask

    task automatic test_start_while_busy();
        build_exp(100, 4);
        run_stream(100, 4, 100, -1, 0, 2, -1);
        checks++; if (byte_mismatches() != 0 || addr_mismatches() != 0) begin errors++; $display("FAIL busy_start: %0d byte and %0d address mismatches expected 0", byte_mismatches(), addr_mismatches()); end
        checks++; if (done_cnt != 1 || checksum !== 8'hAA) begin errors++; $display("FAIL busy_start_end: done %0d checksum %0h expected 1 aa", done_cnt, checksum); end
    endtask

    task automatic test_abort();
        int late;
        run_stream(100, 4, 100, -1, 0, 0, 1);
        @(negedge clk);
        abort = 1'b0; rd_ready = 1'b0;
        checks++; if (rd_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_idle: rd_valid %b busy %b expected 0 0", rd_valid, busy); end
        checks++; if (checksum !== 8'h11) begin errors++; $display("FAIL abort_checksum: got %0h expected 11", checksum); end
        late = (done === 1'b1) ? 1 : 0;
        repeat (4) begin
            @(negedge clk);
            if (done === 1'b1 || rd_valid === 1'b1) late++;
        end
        checks++; if (late != 0) begin errors++; $display("FAIL abort_no_done: %0d cycles with done/rd_valid, expected 0", late); end
        // abort while idle must leave everything as is
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++; if (busy !== 1'b0 || checksum !== 8'h11) begin errors++; $display("FAIL abort_in_idle: busy %b checksum %0h expected 0 11", busy, checksum); end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        start = 1'b1; base_addr = AW'(100); length = (AW+1)'(4);
        @(negedge clk);
        start = 1'b0;
        checks++; if (busy !== 1'b1 || address !== AW'(100)) begin errors++; $display("FAIL rstmid_pre: busy %b address %0d expected 1 100", busy, address); end
        #2 rst = 1'b0;
        #1;
        checks++; if (address !== '0 || busy !== 1'b0 || rd_valid !== 1'b0 || done !== 1'b0 || checksum !== '0) begin
            errors++; $display("FAIL rstmid_async: address %0d busy %b rd_valid %b done %b checksum %0h expected all 0", address, busy, rd_valid, done, checksum);
        end
        @(negedge clk);
        rst = 1'b1;
        build_exp(100, 1);
        run_stream(100, 1, 100, -1, 0, 0, -1);
        checks++; if (got_q.size() != 1 || byte_mismatches() != 0) begin errors++; $display("FAIL rstmid_restart: %0d bytes, %0d mismatches, expected 1 byte 11", got_q.size(), byte_mismatches()); end
        checks++; if (done_cnt != 1 || checksum !== 8'h11) begin errors++; $display("FAIL rstmid_done: done %0d checksum %0h expected 1 11", done_cnt, checksum); end
    endtask

    task automatic test_random();
        int b, n, pct, poke;
        for (int t = 0; t < 8; t++) begin
            b    = ($urandom_range(1) == 1) ? DEPTH - 1 - $urandom_range(0, 6) : $urandom_range(0, DEPTH - 1);
            n    = $urandom_range(1, 24);
            pct  = $urandom_range(30, 100);
            poke = $urandom_range(0, 3);
            build_exp(b, n);
            run_stream(b, n, pct, $urandom_range(0, n - 1), $urandom_range(0, 4), poke, -1);
            checks++; if (timed_out != 0 || byte_mismatches() != 0 || addr_mismatches() != 0) begin
                errors++; $display("FAIL rand_stream: base %0d len %0d timeout %0d byte mm %0d addr mm %0d", b, n, timed_out, byte_mismatches(), addr_mismatches());
            end
            checks++; if (checksum !== exp_sum || done_cnt != 1) begin errors++; $display("FAIL rand_end: base %0d len %0d checksum %0h expected %0h done %0d", b, n, checksum, exp_sum, done_cnt); end
            checks++; if (stable_viol != 0 || busy_viol != 0) begin errors++; $display("FAIL rand_protocol: stable %0d busy %0d violations", stable_viol, busy_viol); end
        end
    endtask

    task automatic test_full_ram();
        int b;
        b = $urandom_range(0, DEPTH - 1);
        build_exp(b, DEPTH);
        run_stream(b, DEPTH, 100, -1, 0, 0, -1);
        checks++; if (timed_out != 0 || got_q.size() != DEPTH) begin errors++; $display("FAIL full_count: %0d bytes timeout %0d expected %0d", got_q.size(), timed_out, DEPTH); end
        checks++; if (byte_mismatches() != 0 || addr_mismatches() != 0) begin errors++; $display("FAIL full_data: byte mm %0d addr mm %0d expected 0", byte_mismatches(), addr_mismatches()); end
        checks++; if (checksum !== exp_sum || done_cnt != 1) begin errors++; $display("FAIL full_end: checksum %0h expected %0h done %0d", checksum, exp_sum, done_cnt); end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero_length();
        test_start_while_busy();
        test_abort();
        test_reset_mid();
        test_random();
        test_full_ram();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
